rs_dispatch: RTL

//  Receiving end of the fetch->RS issue interface. Serves two requests from fetch:
//   - instruction dispatch: accepts an instruction into a free station entry, or refuses it;
//   - register-status read: returns a register's producer tag and value (used for bgt).

---
 rtl/rs_dispatch_pkg.sv | 74 +++++++
 rtl/rs_prio_enc.sv | 22 ++
 rtl/rs_dispatch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rs_dispatch_pkg.sv
// rtl/rs_dispatch_pkg.sv - shared widths, unit codes, entry types and operand helpers
// for the reservation-station dispatch block.
package rs_dispatch_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 6;
  localparam int UNIT_SIZE = 3;
  localparam int TAG_SIZE  = 8;
  localparam int NUM_REGS  = 1 << REG_SIZE;
  localparam logic [TAG_SIZE-1:0] TAG_READY = 8'h7F;

  typedef enum logic [UNIT_SIZE-1:0] {
    UNIT_LW   = 3'd0,
    UNIT_SW   = 3'd1,
    UNIT_ADD  = 3'd2,
    UNIT_MUL  = 3'd3,
    UNIT_MV   = 3'd4,
    UNIT_HALT = 3'd5
  } unit_e;

  typedef struct packed {
    logic                 rdy;
    logic [TAG_SIZE-1:0]  tag;
    logic [WORD_SIZE-1:0] val;
  } operand_t;

  typedef struct packed {
    logic                 valid;
    logic [UNIT_SIZE-1:0] unit;
    operand_t             a;
    operand_t             b;
    operand_t             c;
  } entry_t;

  function automatic logic has_dest(input logic [UNIT_SIZE-1:0] u);
    return (u == UNIT_LW) || (u == UNIT_ADD) || (u == UNIT_MUL) || (u == UNIT_MV);
  endfunction

  function automatic operand_t imm_op(input logic [WORD_SIZE-1:0] v);
    operand_t o;
    o.rdy = 1'b1;
    o.tag = TAG_READY;
    o.val = v;
    return o;
  endfunction

  // Register lookup with same-cycle CDB forwarding.
  function automatic operand_t resolve(input logic [TAG_SIZE-1:0] t, input logic [WORD_SIZE-1:0] v,
                                       input logic hit, input logic [TAG_SIZE-1:0] ctag,
                                       input logic [WORD_SIZE-1:0] cval);
    operand_t o;
    o = imm_op(v);
    if (t != TAG_READY) begin
      if (hit && (t == ctag)) begin
        o.val = cval;
      end else begin
        o.rdy = 1'b0;
        o.tag = t;
      end
    end
    return o;
  endfunction

  function automatic operand_t wake(input operand_t o, input logic hit,
                                    input logic [TAG_SIZE-1:0] ctag, input logic [WORD_SIZE-1:0] cval);
    operand_t r;
    r = o;
    if (hit && !o.rdy && (o.tag == ctag)) begin
      r = imm_op(cval);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// rtl/rs_prio_enc.sv - lowest-set-bit encoder returning index and found flag.
module rs_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_dispatch.sv
// rtl/rs_dispatch.sv - reservation station: dispatch with register renaming,
// register-status reads, CDB wakeup and valid/ready issue to execute.
module rs_dispatch
  import rs_dispatch_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [UNIT_SIZE-1:0] unit,
  input  logic [REG_SIZE-1:0]  reg1,
  input  logic [REG_SIZE-1:0]  reg2,
  input  logic [REG_SIZE-1:0]  reg3,
  input  logic                 hasimm,
  input  logic [WORD_SIZE-1:0] imm,
  output logic                 out,
  input  logic                 regread,
  input  logic [REG_SIZE-1:0]  regin,
  output logic [TAG_SIZE-1:0]  regout,
  output logic [WORD_SIZE-1:0] regoutrf,
  input  logic                 cdb_valid,
  input  logic [TAG_SIZE-1:0]  cdb_tag,
  input  logic [WORD_SIZE-1:0] cdb_value,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [UNIT_SIZE-1:0] ex_unit,
  output logic [TAG_SIZE-1:0]  ex_tag,
  output logic [WORD_SIZE-1:0] ex_a,
  output logic [WORD_SIZE-1:0] ex_b,
  output logic [WORD_SIZE-1:0] ex_c,
  output logic                 halted
);

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [TAG_SIZE-1:0]  rtag_q [NUM_REGS];
  logic [TAG_SIZE-1:0]  rtag_d [NUM_REGS];
  logic [WORD_SIZE-1:0] rval_q [NUM_REGS];
  logic [WORD_SIZE-1:0] rval_d [NUM_REGS];
  entry_t               ent_q  [NUM_ENTRIES];
  entry_t               ent_d  [NUM_ENTRIES];
  logic                 halted_q, lock_q;
  logic [IW-1:0]        lock_idx_q;

  logic [NUM_ENTRIES-1:0] free_vec, rdy_vec;
  logic [IW-1:0]          free_idx, rdy_idx, sel_idx;
  logic                   free_found, rdy_found;
  logic                   cdb_hit, is_halt, alloc, fire;
  operand_t               rd_op;
  entry_t                 new_ent;
  logic [TAG_SIZE-1:0]    new_tag;

  assign cdb_hit = cdb_valid && (cdb_tag != TAG_READY);

  assign rd_op    = resolve(rtag_q[regin], rval_q[regin], cdb_hit, cdb_tag, cdb_value);
  assign regout   = rd_op.tag;
  assign regoutrf = rd_op.val;

  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      free_vec[e] = !ent_q[e].valid;
      rdy_vec[e]  = ent_q[e].valid && ent_q[e].a.rdy && ent_q[e].b.rdy && ent_q[e].c.rdy;
    end
  end

  rs_prio_enc #(.N(NUM_ENTRIES), .IW(IW)) u_free_enc (
    .req_i(free_vec), .idx_o(free_idx), .found_o(free_found)
  );

  rs_prio_enc #(.N(NUM_ENTRIES), .IW(IW)) u_rdy_enc (
    .req_i(rdy_vec), .idx_o(rdy_idx), .found_o(rdy_found)
  );

  assign is_halt = (unit == UNIT_HALT);
  assign out     = enable && !regread && !halted_q && (is_halt || free_found);
  assign alloc   = out && !is_halt;
  assign new_tag = {{(TAG_SIZE-IW){1'b0}}, free_idx};

  // Unused operand slots are marked ready so readiness is a plain AND of all three.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.unit  = unit;
    if ((unit == UNIT_MV) && hasimm) new_ent.a = imm_op(imm);
    else new_ent.a = resolve(rtag_q[reg2], rval_q[reg2], cdb_hit, cdb_tag, cdb_value);
    if (unit == UNIT_MV) new_ent.b = imm_op('0);
    else if (hasimm) new_ent.b = imm_op(imm);
    else new_ent.b = resolve(rtag_q[reg3], rval_q[reg3], cdb_hit, cdb_tag, cdb_value);
    if (unit == UNIT_SW) new_ent.c = resolve(rtag_q[reg1], rval_q[reg1], cdb_hit, cdb_tag, cdb_value);
    else new_ent.c = imm_op('0);
  end

  // A stalled offer stays locked so a newly ready lower entry cannot change it.
  assign sel_idx  = lock_q ? lock_idx_q : rdy_idx;
  assign ex_valid = lock_q || rdy_found;
  assign ex_unit  = ent_q[sel_idx].unit;
  assign ex_tag   = {{(TAG_SIZE-IW){1'b0}}, sel_idx};
  assign ex_a     = ent_q[sel_idx].a.val;
  assign ex_b     = ent_q[sel_idx].b.val;
  assign ex_c     = ent_q[sel_idx].c.val;
  assign fire     = ex_valid && ex_ready;
  assign halted   = halted_q;

  always_comb begin
    rtag_d = rtag_q;
    rval_d = rval_q;
    ent_d  = ent_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cdb_hit && (rtag_q[r] == cdb_tag)) begin
        rval_d[r] = cdb_value;
        rtag_d[r] = TAG_READY;
      end
    end
    if (alloc && has_dest(unit)) rtag_d[reg1] = new_tag;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      ent_d[e].a = wake(ent_q[e].a, cdb_hit, cdb_tag, cdb_value);
      ent_d[e].b = wake(ent_q[e].b, cdb_hit, cdb_tag, cdb_value);
      ent_d[e].c = wake(ent_q[e].c, cdb_hit, cdb_tag, cdb_value);
    end
    if (fire) ent_d[sel_idx].valid = 1'b0;
    if (alloc) ent_d[free_idx] = new_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rtag_q     <= '{default: TAG_READY};
      rval_q     <= '{default: '0};
      ent_q      <= '{default: '0};
      halted_q   <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rtag_q     <= rtag_d;
      rval_q     <= rval_d;
      ent_q      <= ent_d;
      halted_q   <= halted_q || (out && is_halt);
      lock_q     <= ex_valid && !ex_ready;
      lock_idx_q <= sel_idx;
    end
  end

endmodule
